// File: rtl/log_divider.sv
// log_divider: multi-cycle unsigned 8-bit / 8-bit divider using Mitchell's logarithmic
// approximation. The result is a Q8.8 quotient.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   start        begin a division (only honoured while ready=1)
//   a, b         unsigned dividend / divisor, sampled on the accepting edge only
//   ready        idle and able to accept start
//   done         one-cycle pulse; quotient/div_by_zero valid from this cycle on
//   quotient     Q8.8 approximation of a/b (16'hFFFF when b==0)
//   div_by_zero  set with the result when b was 0
//
// Sequence: IDLE -> NORM (7 cycles) -> CALC -> ANTI -> DONE -> IDLE.
// Every output is a flop, so there is no combinational input-to-output path.
module log_divider #(
  parameter logic [6:0] CORR = 7'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        ready,
  output logic        done,
  output logic [15:0] quotient,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {StIdle, StNorm, StCalc, StAnti, StDone} state_e;

  state_e             state_q, state_d;
  logic [7:0]         ra_q, ra_d;
  logic [7:0]         rb_q, rb_d;
  logic [2:0]         ka_q, ka_d;
  logic [2:0]         kb_q, kb_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [6:0]         frac_q, frac_d;
  logic signed [4:0]  e_q, e_d;
  logic [15:0]        quotient_q, quotient_d;
  logic               dbz_q, dbz_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;

  // Log-domain subtraction terms, valid once normalisation is finished.
  logic signed [4:0]  k;
  logic               borrow;
  logic [6:0]         diff;
  logic [6:0]         corr_amt;
  logic [6:0]         frac_adj;
  logic signed [4:0]  e_calc;

  // Antilog terms.
  logic [7:0]         mant;
  logic [3:0]         shl;
  logic [2:0]         shr;
  logic [15:0]        shifted;

  always_comb begin
    k        = 5'({2'b00, ka_q}) - 5'({2'b00, kb_q});
    borrow   = ra_q[6:0] < rb_q[6:0];
    diff     = ra_q[6:0] - rb_q[6:0];  // wraps mod 128 in the borrow case
    corr_amt = borrow ? (CORR >> 1) : CORR;
    frac_adj = (diff > corr_amt) ? (diff - corr_amt) : 7'd0;
    e_calc   = borrow ? (k - 5'sd1) : k;

    mant     = {1'b1, frac_q};
    shl      = e_q[3:0] + 4'd1;  // e in 0..7 -> shift 1..8
    shr      = ~e_q[2:0];        // e in -8..-1 -> -(e+1) = 7..0
    shifted  = e_q[4] ? ({8'h00, mant} >> shr) : ({8'h00, mant} << shl);
  end

  always_comb begin
    state_d    = state_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    ka_d       = ka_q;
    kb_d       = kb_q;
    cnt_d      = cnt_q;
    frac_d     = frac_q;
    e_d        = e_q;
    quotient_d = quotient_q;
    dbz_d      = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          ka_d    = 3'd7;
          kb_d    = 3'd7;
          cnt_d   = 3'd0;
          state_d = StNorm;
        end
      end
      StNorm: begin
        // A zero operand never shifts; it is caught as a special case in ANTI.
        if (ra_q != 8'd0 && !ra_q[7]) begin
          ra_d = ra_q << 1;
          ka_d = ka_q - 3'd1;
        end
        if (rb_q != 8'd0 && !rb_q[7]) begin
          rb_d = rb_q << 1;
          kb_d = kb_q - 3'd1;
        end
        if (cnt_q == 3'd6) begin
          state_d = StCalc;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StCalc: begin
        frac_d  = frac_adj;
        e_d     = e_calc;
        state_d = StAnti;
      end
      StAnti: begin
        if (rb_q == 8'd0) begin
          quotient_d = 16'hFFFF;
          dbz_d      = 1'b1;
        end else if (ra_q == 8'd0) begin
          quotient_d = 16'h0000;
          dbz_d      = 1'b0;
        end else begin
          quotient_d = shifted;
          dbz_d      = 1'b0;
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Handshake outputs are registered from the next state.
    ready_d = (state_d == StIdle);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ra_q       <= 8'd0;
      rb_q       <= 8'd0;
      ka_q       <= 3'd0;
      kb_q       <= 3'd0;
      cnt_q      <= 3'd0;
      frac_q     <= 7'd0;
      e_q        <= 5'sd0;
      quotient_q <= 16'h0000;
      dbz_q      <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      ka_q       <= ka_d;
      kb_q       <= kb_d;
      cnt_q      <= cnt_d;
      frac_q     <= frac_d;
      e_q        <= e_d;
      quotient_q <= quotient_d;
      dbz_q      <= dbz_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_log_divider.sv
// Self-checking bench for log_divider: hand-computed vector table, multi-cycle corner
// sequences (continuous start, reset mid-operation, reset priority) and a random sweep
// against an independent reference model.
module tb_log_divider;

  localparam int CorrTb = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        done;
  logic [15:0] quotient;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  log_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] q;
    logic        dbz;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: priority-encoder based Mitchell approximation, returns {dbz, quotient}.
  function automatic logic [16:0] model(input logic [7:0] aa, input logic [7:0] bb);
    int pa, pb, fa, fb, k, e, frac, m, q;
    logic [31:0] qv;
    if (bb == 8'd0) return {1'b1, 16'hFFFF};
    if (aa == 8'd0) return 17'h0;
    pa = 0;
    pb = 0;
    for (int i = 0; i < 8; i++) begin
      if (aa[i]) pa = i;
      if (bb[i]) pb = i;
    end
    fa = (int'(aa) << (7 - pa)) & 127;
    fb = (int'(bb) << (7 - pb)) & 127;
    k  = pa - pb;
    if (fa >= fb) begin
      frac = fa - fb - CorrTb;
      e    = k;
    end else begin
      frac = fa - fb + 128 - (CorrTb / 2);
      e    = k - 1;
    end
    if (frac < 0) frac = 0;
    m  = 128 + frac;
    q  = (e >= 0) ? (m << (e + 1)) : (m >> (-(e + 1)));
    qv = q;
    return {1'b0, qv[15:0]};
  endfunction

  // Called at a negedge with the DUT idle. Returns at the negedge after DONE.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, output logic [15:0] oq,
                        output logic odbz, output int lat);
    int nrdy_low;
    start = 1'b1;
    a     = ia;
    b     = ib;
    @(negedge clk);
    start    = 1'b0;
    a        = ~ia;  // operands must not be resampled after acceptance
    b        = ib ^ 8'h5A;
    nrdy_low = (ready == 1'b0) ? 1 : 0;
    lat      = -1;
    oq       = 16'hxxxx;
    odbz     = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready == 1'b0) nrdy_low++;
      if (done) begin
        lat  = i;
        oq   = quotient;
        odbz = div_by_zero;
        break;
      end
    end
    chk("latency", lat, 9);
    chk("ready_low_cycles", nrdy_low, 10);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("ready_after_done", {31'd0, ready}, 1);
  endtask

  logic [15:0] rq;
  logic        rdbz;
  int          rlat;
  logic [16:0] exp_r;
  logic [7:0]  op_a[34];
  logic [7:0]  op_b[34];
  int          seen;

  initial begin
    vecs[0]  = '{8'd8,   8'd2,   16'h0400, 1'b0};
    vecs[1]  = '{8'd255, 8'd1,   16'hF500, 1'b0};
    vecs[2]  = '{8'd3,   8'd2,   16'h016C, 1'b0};
    vecs[3]  = '{8'd12,  8'd3,   16'h0400, 1'b0};
    vecs[4]  = '{8'd2,   8'd3,   16'h00BB, 1'b0};
    vecs[5]  = '{8'd0,   8'd5,   16'h0000, 1'b0};
    vecs[6]  = '{8'd7,   8'd0,   16'hFFFF, 1'b1};
    vecs[7]  = '{8'd0,   8'd0,   16'hFFFF, 1'b1};
    vecs[8]  = '{8'd1,   8'd255, 16'h0001, 1'b0};
    vecs[9]  = '{8'd128, 8'd1,   16'h8000, 1'b0};
    vecs[10] = '{8'd5,   8'd2,   16'h0258, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 1);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_quotient", {16'd0, quotient}, 0);
    chk("rst_dbz", {31'd0, div_by_zero}, 0);

    // Start on the very first edge with reset released.
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, rq, rdbz, rlat);
      chk($sformatf("vec%0d_quotient", i), {16'd0, rq}, {16'd0, vecs[i].q});
      chk($sformatf("vec%0d_dbz", i), {31'd0, rdbz}, {31'd0, vecs[i].dbz});
    end

    // start held high continuously: accepts only when idle, every 11 cycles.
    for (int c = 0; c < 34; c++) begin
      op_a[c] = 8'(c * 37 + 5);
      op_b[c] = 8'(c * 11 + 3);
    end
    for (int c = 0; c < 34; c++) begin
      if (c == 10 || c == 21 || c == 32) begin
        exp_r = model(op_a[c-10], op_b[c-10]);
        chk($sformatf("cont_done_c%0d", c), {31'd0, done}, 1);
        chk($sformatf("cont_q_c%0d", c), {16'd0, quotient}, {16'd0, exp_r[15:0]});
      end else begin
        chk($sformatf("cont_done_c%0d", c), {31'd0, done}, 0);
      end
      start = 1'b1;
      a     = op_a[c];
      b     = op_b[c];
      @(negedge clk);
    end
    start = 1'b0;
    seen  = 0;
    for (int i = 0; i < 20; i++) begin
      if (ready) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    chk("cont_drain_ready", seen, 1);

    // Reset priority over start.
    rst_n = 1'b0;
    start = 1'b1;
    a     = 8'd9;
    b     = 8'd3;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("rstprio_ready", {31'd0, ready}, 1);

    // Nonzero result in place, then reset during NORM.
    run_op(8'd255, 8'd1, rq, rdbz, rlat);
    start = 1'b1;
    a     = 8'd200;
    b     = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("norm_rst_ready", {31'd0, ready}, 1);
    chk("norm_rst_done", {31'd0, done}, 0);
    chk("norm_rst_quotient", {16'd0, quotient}, 0);
    chk("norm_rst_dbz", {31'd0, div_by_zero}, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("norm_rst_no_done", seen, 0);

    // Reset during DONE.
    start = 1'b1;
    a     = 8'd7;
    b     = 8'd0;
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk("done_rst_reached", seen, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("done_rst_ready", {31'd0, ready}, 1);
    chk("done_rst_done", {31'd0, done}, 0);
    chk("done_rst_quotient", {16'd0, quotient}, 0);
    chk("done_rst_dbz", {31'd0, div_by_zero}, 0);
    run_op(8'd3, 8'd2, rq, rdbz, rlat);
    chk("after_rst_quotient", {16'd0, rq}, 32'h016C);

    // Random sweep against the reference model.
    for (int i = 0; i < 1200; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i < 16) rb = 8'(i);  // force the small / zero divisor corners
      exp_r = model(ra, rb);
      run_op(ra, rb, rq, rdbz, rlat);
      chk($sformatf("sweep_%0d_%0d", ra, rb), {15'd0, rdbz, rq}, {15'd0, exp_r});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
